// File: rtl/pulse_seq_pkg.sv
// Purpose: shared types and step indices for the pulse sequence scheduler.
// Contents: FSM state enum and the step numbers used by the pulse decode
//           (step k of a sequence fires when the step counter reaches k*GAP).
package pulse_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN_A, RUN_B, RUN_AB} pseq_state_e;

  localparam int STEP_0 = 0;
  localparam int STEP_1 = 1;
  localparam int STEP_2 = 2;

endpackage

// File: rtl/pulse_seq_scheduler_rr_arb2.sv
// Purpose: two-requester round-robin arbiter with a 1-bit priority pointer.
// Latency: win_a/win_b are combinational from the requests; the pointer
//          updates on the clock only when upd is high.
// Ports: clk, rst_n (async active-low), req_a/req_b requests, upd pointer
//        update enable, win_a/win_b one-hot (or zero) winner.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic upd,
  output logic win_a,
  output logic win_b
);

  // 0: A has priority, 1: B has priority
  logic ptr;

  always_comb begin
    win_a = req_a & (~req_b | ~ptr);
    win_b = req_b & (~req_a | ptr);
  end

  // The winner drops to lowest priority: if A won, B gets priority next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (upd) begin
      ptr <= win_a;
    end
  end

endmodule

// File: rtl/pulse_seq_scheduler.sv
// Purpose: shares one timed pulse engine between requesters A (v1,v2) and
//          B (v3,v4,v5); conc_en runs both sequences aligned.
// Ports: clk, rst_n (async active-low), req_a/req_b level requests, conc_en;
//        outputs gnt_a/gnt_b, busy, v1..v5, done_a/done_b, all registered.
module pulse_seq_scheduler
  import pulse_seq_pkg::*;
#(
  parameter int GAP = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic conc_en,
  output logic gnt_a,
  output logic gnt_b,
  output logic busy,
  output logic v1,
  output logic v2,
  output logic v3,
  output logic v4,
  output logic v5,
  output logic done_a,
  output logic done_b
);

  localparam int CNT_W = $clog2(2 * GAP + 1);

  if (GAP < 1) begin : g_gap_check
    $error("pulse_seq_scheduler: GAP must be >= 1");
  end

  localparam logic [CNT_W-1:0] T0 = CNT_W'(STEP_0 * GAP);
  localparam logic [CNT_W-1:0] T1 = CNT_W'(STEP_1 * GAP);
  localparam logic [CNT_W-1:0] T2 = CNT_W'(STEP_2 * GAP);

  pseq_state_e      state, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             win_a, win_b, arb_upd;
  logic             a_run, b_run;
  logic             v1_d, v2_d, v3_d, v4_d, v5_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_a (req_a),
    .req_b (req_b),
    .upd   (arb_upd),
    .win_a (win_a),
    .win_b (win_b)
  );

  // Saturating increment; a run exits at T2 at the latest so it never wraps.
  assign cnt_inc = (cnt == T2) ? cnt : cnt + 1'b1;

  always_comb begin
    st_nxt  = state;
    cnt_nxt = cnt;
    arb_upd = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (req_a && req_b) begin
          if (conc_en) begin
            st_nxt = RUN_AB;
          end else begin
            // Only a contended grant moves the round-robin pointer.
            arb_upd = 1'b1;
            st_nxt  = win_a ? RUN_A : RUN_B;
          end
        end else if (req_a) begin
          st_nxt = RUN_A;
        end else if (req_b) begin
          st_nxt = RUN_B;
        end
      end
      RUN_A: begin
        if (cnt == T1) begin
          st_nxt  = IDLE;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      RUN_B, RUN_AB: begin
        if (cnt == T2) begin
          st_nxt  = IDLE;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        st_nxt  = IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  // Pulses are decoded from the next state/count so they land in the same
  // cycle the counter reaches the step value. Inside a run the counter is
  // never 0 again, so the step-0 pulses only fire on the start edge.
  always_comb begin
    a_run = (st_nxt == RUN_A) || (st_nxt == RUN_AB);
    b_run = (st_nxt == RUN_B) || (st_nxt == RUN_AB);
    v1_d  = a_run && (cnt_nxt == T0);
    v2_d  = a_run && (cnt_nxt == T1);
    v3_d  = b_run && (cnt_nxt == T0);
    v4_d  = b_run && (cnt_nxt == T1);
    v5_d  = b_run && (cnt_nxt == T2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      v4    <= 1'b0;
      v5    <= 1'b0;
    end else begin
      state <= st_nxt;
      cnt   <= cnt_nxt;
      v1    <= v1_d;
      v2    <= v2_d;
      v3    <= v3_d;
      v4    <= v4_d;
      v5    <= v5_d;
    end
  end

  // Grants and dones are coincident with the first/last pulse of each
  // sequence, so they share those flops.
  assign gnt_a  = v1;
  assign gnt_b  = v3;
  assign done_a = v2;
  assign done_b = v5;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_pulse_seq_scheduler.sv
// Purpose: directed self-checking bench for pulse_seq_scheduler (GAP=2 and GAP=1).
// Ports: none; drives clk/rst_n/requests and compares a 10-bit output vector
//        {gnt_a,gnt_b,busy,v1,v2,v3,v4,v5,done_a,done_b} per cycle.
module tb_pulse_seq_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, req_a, req_b, conc_en, req_a1, req_b1;
  logic gnt_a, gnt_b, busy, v1, v2, v3, v4, v5, done_a, done_b;
  logic gnt_a1, gnt_b1, busy1, w1, w2, w3, w4, w5, done_a1, done_b1;

  pulse_seq_scheduler #(.GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .conc_en(conc_en),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy),
    .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v5(v5),
    .done_a(done_a), .done_b(done_b)
  );

  pulse_seq_scheduler #(.GAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a1), .req_b(req_b1), .conc_en(1'b0),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .busy(busy1),
    .v1(w1), .v2(w2), .v3(w3), .v4(w4), .v5(w5),
    .done_a(done_a1), .done_b(done_b1)
  );

  wire [9:0] obs  = {gnt_a, gnt_b, busy, v1, v2, v3, v4, v5, done_a, done_b};
  wire [9:0] obs1 = {gnt_a1, gnt_b1, busy1, w1, w2, w3, w4, w5, done_a1, done_b1};

  // Sequence properties on the GAP=2 instance.
  a_s1: assert property (@(posedge clk) disable iff (!rst_n) v1 |-> ##2 v2);
  a_s2: assert property (@(posedge clk) disable iff (!rst_n) v3 |-> ##2 v4 ##2 v5);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Called at a negedge with requests already driven; the next posedge is c0.
  task automatic run_trace(input string tag, input bit sel1, input logic [9:0] exp[$],
                           input bit hold, input bit poke);
    for (int i = 0; i < exp.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s c%0d", tag, i), sel1 ? obs1 : obs, exp[i]);
      if (i == 0 && !hold) begin
        req_a = 0; req_b = 0; req_a1 = 0; req_b1 = 0;
      end
      if (poke && i == 1) req_a = 1;
      if (poke && i == 3) req_a = 0;
    end
  endtask

  logic [9:0] tA[$], tB[$], tAB[$], t4[$], tB2[$], tB1[$], tA1[$];

  initial begin
    tA  = '{10'b1011000000, 10'b0010000000, 10'b0010100010, 10'b0000000000};
    tB  = '{10'b0110010000, 10'b0010000000, 10'b0010001000, 10'b0010000000,
            10'b0010000101, 10'b0000000000};
    tAB = '{10'b1111010000, 10'b0010000000, 10'b0010101010, 10'b0010000000,
            10'b0010000101, 10'b0000000000};
    t4  = {tA, tB, tA, tB[0:4]};
    tB2 = {tB, 10'b0000000000, 10'b0000000000};
    tB1 = '{10'b0110010000, 10'b0010001000, 10'b0010000101, 10'b0000000000};
    tA1 = '{10'b1011000000, 10'b0010100010, 10'b0000000000};

    rst_n = 0; req_a = 0; req_b = 0; conc_en = 0; req_a1 = 0; req_b1 = 0;
    #1;
    chk("reset dut", obs, 10'b0);
    chk("reset dut1", obs1, 10'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // 1: A alone
    req_a = 1;
    run_trace("t1_a", 0, tA, 0, 0);

    // 2: B alone; a short req_a pulse during the run must not be served
    req_b = 1;
    run_trace("t2_b", 0, tB2, 0, 1);

    // 3: both with conc_en -> aligned run
    req_a = 1; req_b = 1; conc_en = 1;
    run_trace("t3_ab", 0, tAB, 0, 0);
    conc_en = 0;

    // 4: contended, held, from reset -> alternating A/B
    rst_n = 0;
    @(negedge clk);
    rst_n = 1; req_a = 1; req_b = 1;
    run_trace("t4_rr", 0, t4, 1, 0);
    req_a = 0; req_b = 0;
    @(negedge clk);
    chk("t4 tail idle", obs, 10'b0);

    // 5: reset during RUN_B, then a fresh B run
    req_b = 1;
    @(negedge clk);
    chk("t5 c0", obs, 10'b0110010000);
    @(posedge clk);
    #1;
    chk("t5 c1", obs, 10'b0010000000);
    rst_n = 0;
    #1;
    chk("t5 async clr", obs, 10'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t5 in reset %0d", i), obs, 10'b0);
    end
    rst_n = 1;
    run_trace("t5_fresh", 0, tB, 0, 0);

    // 6: GAP=1 instance
    req_b1 = 1;
    run_trace("t6_b_gap1", 1, tB1, 0, 0);
    req_a1 = 1;
    run_trace("t6_a_gap1", 1, tA1, 0, 0);
    chk("t6 dut idle", obs, 10'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
